mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 42 ++++
 rtl/mem_decoder.sv | 17 +
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the memory arbiter and its address decoder.
package mem_arbiter_pkg;

    localparam int NUM_SLV   = 4;
    localparam int SLV_ROM   = 0;
    localparam int SLV_PRINT = 1;
    localparam int SLV_CLINT = 2;
    localparam int SLV_BRAM  = 3;

    // System address map, half-open [base, top)
    localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
    localparam logic [31:0] ROM_TOP    = 32'h0000_0080;
    localparam logic [31:0] PRINT_BASE = 32'h0100_0000;
    localparam logic [31:0] PRINT_TOP  = 32'h0100_0004;
    localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] CLINT_TOP  = 32'h0200_C000;
    localparam logic [31:0] BRAM_BASE  = 32'h8000_0000;
    localparam logic [31:0] BRAM_TOP   = 32'h9000_0000;

    // Indexed by slave number (element 0 is rom)
    localparam logic [NUM_SLV-1:0][31:0] SLV_BASE = {BRAM_BASE, CLINT_BASE, PRINT_BASE, ROM_BASE};
    localparam logic [NUM_SLV-1:0][31:0] SLV_TOP  = {BRAM_TOP,  CLINT_TOP,  PRINT_TOP,  ROM_TOP};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_ERR
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    function automatic logic in_range(input logic [31:0] a, input logic [31:0] base,
                                      input logic [31:0] top);
        return (a >= base) && (a < top);
    endfunction

endpackage

// File: rtl/mem_decoder.sv
// Combinational address decode to a one-hot slave select plus hit flag.
module mem_decoder
    import mem_arbiter_pkg::*;
(
    input  logic [31:0]        addr,
    output logic [NUM_SLV-1:0] sel,
    output logic               hit
);

    for (genvar i = 0; i < NUM_SLV; i++) begin : g_rng
        assign sel[i] = in_range(addr, SLV_BASE[i], SLV_TOP[i]);
    end

    // Ranges are disjoint, so at most one bit is set
    assign hit = |sel;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto the shared slave fabric, one transaction in flight.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit rr_enable = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          imem_valid,
    input  logic [31:0]                   imem_addr,
    input  logic [31:0]                   imem_wdata,
    input  logic [3:0]                    imem_wstrb,
    output logic [31:0]                   imem_rdata,
    output logic                          imem_ready,
    output logic                          imem_error,
    input  logic                          dmem_valid,
    input  logic [31:0]                   dmem_addr,
    input  logic [31:0]                   dmem_wdata,
    input  logic [3:0]                    dmem_wstrb,
    output logic [31:0]                   dmem_rdata,
    output logic                          dmem_ready,
    output logic                          dmem_error,
    output logic [NUM_SLV-1:0]            slv_valid,
    output logic [31:0]                   slv_addr,
    output logic [31:0]                   slv_wdata,
    output logic [3:0]                    slv_wstrb,
    input  logic [NUM_SLV-1:0][31:0]      slv_rdata,
    input  logic [NUM_SLV-1:0]            slv_ready
);

    state_t             state, state_nxt;
    mem_req_t           req_q, win_req;
    logic [NUM_SLV-1:0] sel_q, win_sel;
    logic               win_hit, pick_d, any_req;
    logic               gnt_d_q;     // granted port; doubles as last-grant (0 = instruction)
    logic               sel_rdy, done, err;
    logic [31:0]        rdata_mux;

    assign any_req = imem_valid | dmem_valid;
    // Data wins when alone, in fixed-priority mode, or when instruction won last
    assign pick_d  = dmem_valid && (!imem_valid || !rr_enable || !gnt_d_q);
    assign win_req = pick_d ? {dmem_addr, dmem_wdata, dmem_wstrb}
                            : {imem_addr, imem_wdata, imem_wstrb};

    mem_decoder u_dec (
        .addr (win_req.addr),
        .sel  (win_sel),
        .hit  (win_hit)
    );

    assign sel_rdy = |(slv_ready & sel_q);

    // Select the granted slave's read data
    always_comb begin
        rdata_mux = '0;
        for (int i = 0; i < NUM_SLV; i++)
            if (sel_q[i]) rdata_mux = rdata_mux | slv_rdata[i];
    end

    // Next state and per-state strobes; reset masks any in-flight completion
    always_comb begin
        state_nxt = state;
        slv_valid = '0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            ST_IDLE: if (any_req) state_nxt = win_hit ? ST_REQ : ST_ERR;
            ST_REQ: begin
                slv_valid = sel_q;
                done      = sel_rdy;
                state_nxt = sel_rdy ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                done = sel_rdy;
                if (sel_rdy) state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                err       = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (reset) begin
            slv_valid = '0;
            done      = 1'b0;
            err       = 1'b0;
        end
    end

    // State register and latch of the granted request
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            req_q   <= '0;
            sel_q   <= '0;
            gnt_d_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && any_req) begin
                req_q   <= win_req;
                sel_q   <= win_sel;
                gnt_d_q <= pick_d;
            end
        end
    end

    assign slv_addr   = req_q.addr;
    assign slv_wdata  = req_q.wdata;
    assign slv_wstrb  = req_q.wstrb;

    assign imem_ready = (done | err) & ~gnt_d_q;
    assign dmem_ready = (done | err) &  gnt_d_q;
    assign imem_error = err & ~gnt_d_q;
    assign dmem_error = err &  gnt_d_q;
    assign imem_rdata = (done & ~gnt_d_q) ? rdata_mux : '0;
    assign dmem_rdata = (done &  gnt_d_q) ? rdata_mux : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; a second instance covers fixed priority.
module tb_mem_arbiter;

    logic              clock = 1'b0;
    logic              reset;
    logic              imem_valid, dmem_valid;
    logic [31:0]       imem_addr, imem_wdata, dmem_addr, dmem_wdata;
    logic [3:0]        imem_wstrb, dmem_wstrb;
    logic [3:0][31:0]  slv_rdata;
    logic [3:0]        slv_ready;

    logic [31:0]       imem_rdata, dmem_rdata, slv_addr, slv_wdata;
    logic              imem_ready, imem_error, dmem_ready, dmem_error;
    logic [3:0]        slv_valid, slv_wstrb;

    logic [31:0]       imem_rdata2, dmem_rdata2, slv_addr2, slv_wdata2;
    logic              imem_ready2, imem_error2, dmem_ready2, dmem_error2;
    logic [3:0]        slv_valid2, slv_wstrb2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.rr_enable(1'b1)) dut (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_wstrb(imem_wstrb), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .imem_error(imem_error),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .dmem_error(dmem_error),
        .slv_valid(slv_valid), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
        .slv_wstrb(slv_wstrb), .slv_rdata(slv_rdata), .slv_ready(slv_ready)
    );

    mem_arbiter #(.rr_enable(1'b0)) dut_fix (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_wstrb(imem_wstrb), .imem_rdata(imem_rdata2), .imem_ready(imem_ready2),
        .imem_error(imem_error2),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata2), .dmem_ready(dmem_ready2),
        .dmem_error(dmem_error2),
        .slv_valid(slv_valid2), .slv_addr(slv_addr2), .slv_wdata(slv_wdata2),
        .slv_wstrb(slv_wstrb2), .slv_rdata(slv_rdata), .slv_ready(slv_ready)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Boundary probe from the instruction port; every slave answers so only the granted one matters
    task automatic probe(input string tag, input logic [31:0] a, input logic [3:0] exp_sv,
                         input logic exp_err);
        imem_valid = 1'b1; imem_addr = a;
        tick();
        slv_ready = 4'hF;
        #1;
        chk({tag, "_slv_valid"}, 32'(slv_valid), 32'(exp_sv));
        chk({tag, "_error"},     32'(imem_error), 32'(exp_err));
        chk({tag, "_ready"},     32'(imem_ready), 32'd1);
        tick();
        imem_valid = 1'b0; slv_ready = '0;
    endtask

    initial begin
        reset = 1'b1;
        imem_valid = 0; imem_addr = 0; imem_wdata = 0; imem_wstrb = 0;
        dmem_valid = 0; dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0;
        slv_rdata = '0; slv_ready = '0;
        tick(); tick();
        chk("rst_slv_valid", 32'(slv_valid), 32'd0);
        chk("rst_ready", 32'({imem_ready, dmem_ready, imem_error, dmem_error}), 32'd0);
        chk("rst_rdata", imem_rdata | dmem_rdata, 32'd0);
        chk("rst_slv_addr", slv_addr | slv_wdata | 32'(slv_wstrb), 32'd0);
        reset = 1'b0;
        tick();

        // Ties: round-robin gives D, I, D; fixed priority gives D, D, D
        imem_valid = 1; imem_addr = 32'h8000_0000;
        dmem_valid = 1; dmem_addr = 32'h8000_0004;
        slv_ready = 4'b1000; slv_rdata[3] = 32'h0000_0011;
        #1;
        chk("tie_idle", 32'({imem_ready, dmem_ready}), 32'd0);
        tick();
        chk("tie1_rr",  32'({imem_ready, dmem_ready}), 32'b01);
        chk("tie1_fix", 32'({imem_ready2, dmem_ready2}), 32'b01);
        chk("tie1_rdata", dmem_rdata, 32'h11);
        chk("tie1_irdata", imem_rdata, 32'h0);
        tick();
        chk("tie_gap", 32'({imem_ready, dmem_ready}), 32'd0);
        tick();
        chk("tie2_rr",  32'({imem_ready, dmem_ready}), 32'b10);
        chk("tie2_fix", 32'({imem_ready2, dmem_ready2}), 32'b01);
        tick();
        tick();
        chk("tie3_rr",  32'({imem_ready, dmem_ready}), 32'b01);
        chk("tie3_fix", 32'({imem_ready2, dmem_ready2}), 32'b01);
        tick();
        imem_valid = 0; dmem_valid = 0; slv_ready = '0;
        tick();

        // Zero-wait bram read
        dmem_valid = 1; dmem_addr = 32'h8000_0010;
        tick();
        slv_ready = 4'b1000; slv_rdata[3] = 32'hDEAD_BEEF;
        #1;
        chk("bram_slv_valid", 32'(slv_valid), 32'b1000);
        chk("bram_ready", 32'(dmem_ready), 32'd1);
        chk("bram_rdata", dmem_rdata, 32'hDEAD_BEEF);
        chk("bram_iready", 32'(imem_ready), 32'd0);
        chk("bram_slv_addr", slv_addr, 32'h8000_0010);
        tick();
        dmem_valid = 0; slv_ready = '0;
        #1;
        chk("bram_after", 32'(dmem_ready), 32'd0);

        // print write with 3 wait states
        dmem_valid = 1; dmem_addr = 32'h0100_0000; dmem_wdata = 32'h41; dmem_wstrb = 4'hF;
        tick();
        chk("pr_slv_valid", 32'(slv_valid), 32'b0010);
        chk("pr_wdata1", slv_wdata, 32'h41);
        chk("pr_wstrb", 32'(slv_wstrb), 32'hF);
        chk("pr_ready1", 32'(dmem_ready), 32'd0);
        tick();
        chk("pr_valid_w", 32'(slv_valid), 32'd0);
        chk("pr_ready2", 32'(dmem_ready), 32'd0);
        tick();
        chk("pr_ready3", 32'(dmem_ready), 32'd0);
        tick();
        slv_ready = 4'b0010;
        #1;
        chk("pr_ready4", 32'(dmem_ready), 32'd1);
        chk("pr_wdata4", slv_wdata, 32'h41);
        tick();
        dmem_valid = 0; dmem_wstrb = 0; slv_ready = '0;
        #1;
        chk("pr_after", 32'(dmem_ready), 32'd0);

        // Unmapped instruction fetch
        slv_rdata[0] = 32'hFFFF_FFFF;
        imem_valid = 1; imem_addr = 32'h4000_0000;
        tick();
        chk("miss_slv_valid", 32'(slv_valid), 32'd0);
        chk("miss_flags", 32'({imem_ready, imem_error, dmem_ready}), 32'b110);
        chk("miss_rdata", imem_rdata, 32'd0);
        tick();
        imem_valid = 0;
        #1;
        chk("miss_after", 32'({imem_ready, imem_error}), 32'd0);

        // Reset during clint wait, late ready ignored, then a normal request
        dmem_valid = 1; dmem_addr = 32'h0200_0008;
        tick();
        chk("cl_slv_valid", 32'(slv_valid), 32'b0100);
        chk("cl_slv_addr", slv_addr, 32'h0200_0008);
        tick();
        reset = 1; dmem_valid = 0;
        #1;
        chk("cl_rst_ready", 32'(dmem_ready), 32'd0);
        tick();
        reset = 0; slv_ready = 4'b0100; slv_rdata[2] = 32'h55;
        #1;
        chk("cl_late_ready", 32'(dmem_ready), 32'd0);
        chk("cl_late_rdata", dmem_rdata, 32'd0);
        chk("cl_rst_slv", 32'(slv_valid), 32'd0);
        chk("cl_rst_addr", slv_addr, 32'd0);
        tick();
        slv_ready = '0;
        dmem_valid = 1; dmem_addr = 32'h0200_0008;
        tick();
        slv_ready = 4'b0100; slv_rdata[2] = 32'h1234;
        #1;
        chk("cl2_slv_valid", 32'(slv_valid), 32'b0100);
        chk("cl2_ready", 32'(dmem_ready), 32'd1);
        chk("cl2_rdata", dmem_rdata, 32'h1234);
        tick();
        dmem_valid = 0; slv_ready = '0;
        tick();

        // Range edges
        probe("b_7c",       32'h0000_007C, 4'b0001, 1'b0);
        probe("b_80",       32'h0000_0080, 4'b0000, 1'b1);
        probe("b_200bffc",  32'h0200_BFFC, 4'b0100, 1'b0);
        probe("b_90000000", 32'h9000_0000, 4'b0000, 1'b1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
